// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus (CDB).
// Holds the write-back widths, the invalid-tag constant and the broadcast packet type.
package cdb_pkg;

  localparam int unsigned DATA_W = 32;  // result width
  localparam int unsigned REG_W  = 5;   // architectural register index width
  localparam int unsigned TAG_W  = 4;   // instruction tag width

  // Tag value meaning "no producer / no broadcast".
  localparam logic [TAG_W-1:0] TAG_INVALID = '0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  tag;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
// master: requester side (drives req_*, observes ready, broadcast and busy count).
// slave:  arbiter side.
interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  localparam int unsigned CNT_W = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0][REG_W-1:0]  req_reg;
  logic [N_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [N_REQ-1:0]             req_ready;

  logic                         cdb_valid;
  logic [DATA_W-1:0]            cdb_data;
  logic [REG_W-1:0]             cdb_reg;
  logic [TAG_W-1:0]             cdb_tag;
  logic [CNT_W-1:0]             busy_cnt;

  modport master (
    output req_valid, req_data, req_reg, req_tag,
    input  req_ready, cdb_valid, cdb_data, cdb_reg, cdb_tag, busy_cnt
  );

  modport slave (
    input  req_valid, req_data, req_reg, req_tag,
    output req_ready, cdb_valid, cdb_data, cdb_reg, cdb_tag, busy_cnt
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans req starting at ptr, wrapping modulo N, and grants the first set bit.
// Ports: req (candidates), ptr (scan start), gnt (one-hot grant), idx (winner index),
//        any (some candidate was found).
module rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c[W-1:0]]) begin
        any            = 1'b1;
        gnt[c[W-1:0]]  = 1'b1;
        idx            = c[W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: shares the single register-file write-back port among
// N_REQ functional units, one round-robin grant per cycle, with a registered broadcast.
// Ports: clk, rst (sync, active-high), flush (drops this cycle's arbitration),
//        bus (slave side: req_* in, req_ready/cdb_*/busy_cnt out).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  cdb_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(N_REQ + 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  cdb_pkt_t         pkt_q, pkt_d;
  logic             valid_q, valid_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;
  logic [CNT_W-1:0] cnt;

  // A request carrying the invalid tag is never a candidate.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = bus.req_valid[i] && (bus.req_tag[i] != TAG_INVALID);
    end
  end

  rr_picker #(
    .N (N_REQ),
    .W (PTR_W)
  ) u_picker (
    .req (cand),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign bus.req_ready = (rst || flush) ? '0 : gnt;

  always_comb begin
    ptr_d   = ptr_q;
    pkt_d   = pkt_q;
    valid_d = 1'b0;
    // Idle default: data/reg hold, tag drops so the register file sees no write.
    pkt_d.tag = TAG_INVALID;
    if (flush) begin
      ptr_d = '0;
    end else if (win_any) begin
      valid_d    = 1'b1;
      pkt_d.data = bus.req_data[win_idx];
      pkt_d.rd   = bus.req_reg[win_idx];
      pkt_d.tag  = bus.req_tag[win_idx];
      ptr_d      = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      pkt_q     <= '0;
      pkt_q.tag <= TAG_INVALID;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign bus.cdb_valid = valid_q;
  assign bus.cdb_data  = pkt_q.data;
  assign bus.cdb_reg   = pkt_q.rd;
  assign bus.cdb_tag   = pkt_q.tag;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt = cnt + CNT_W'(bus.req_valid[i]);
    end
  end

  assign bus.busy_cnt = cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned N_REQ = 4;

  logic clk;
  logic rst;
  logic flush;

  cdb_arbiter_if #(.N_REQ(N_REQ)) bus ();

  cdb_arbiter #(.N_REQ(N_REQ)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int proto_cnt = 0;

  cdb_pkt_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: a valid request with the invalid tag is a requester error.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_tag[i] == TAG_INVALID) begin
          proto_cnt++;
          $display("protocol violation: requester %0d valid with invalid tag", i);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic [DATA_W-1:0] d,
                         input logic [REG_W-1:0] r, input logic [TAG_W-1:0] t);
    bus.req_valid[i] = v;
    bus.req_data[i]  = d;
    bus.req_reg[i]   = r;
    bus.req_tag[i]   = t;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, '0, '0, 4'd1);
  endtask

  // One arbitration cycle: check the grant mid-cycle, push the expected broadcast,
  // then check the registered broadcast just after the edge.
  task automatic step(input string name, input logic [N_REQ-1:0] exp_gnt);
    cdb_pkt_t p;
    @(negedge clk);
    chk({name, " ready"}, 32'(bus.req_ready), 32'(exp_gnt));
    for (int i = 0; i < N_REQ; i++) begin
      if (exp_gnt[i]) begin
        exp_q.push_back('{data: bus.req_data[i], rd: bus.req_reg[i], tag: bus.req_tag[i]});
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      chk({name, " cdb_valid"}, 32'(bus.cdb_valid), 32'd1);
      chk({name, " cdb_tag"},   32'(bus.cdb_tag),   32'(p.tag));
      chk({name, " cdb_reg"},   32'(bus.cdb_reg),   32'(p.rd));
      chk({name, " cdb_data"},  32'(bus.cdb_data),  32'(p.data));
    end else begin
      chk({name, " cdb_valid"}, 32'(bus.cdb_valid), 32'd0);
      chk({name, " cdb_tag"},   32'(bus.cdb_tag),   32'(TAG_INVALID));
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " cdb_valid"}, 32'(bus.cdb_valid), 32'd0);
    chk({name, " cdb_tag"},   32'(bus.cdb_tag),   32'd0);
    chk({name, " cdb_data"},  32'(bus.cdb_data),  32'd0);
    chk({name, " cdb_reg"},   32'(bus.cdb_reg),   32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      set_req(i, 1'b1, 32'h1000 + 32'(i), 5'(i + 1), 4'(i + 1));
    end

    // Reset held two cycles with every requester valid.
    repeat (2) begin
      @(negedge clk);
      chk("rst ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk_reset_outputs("rst");
    end
    rst = 1'b0;
    #1;
    chk("busy_all", 32'(bus.busy_cnt), 32'd4);
    step("rst_first", 4'b0001);
    clear_all();
    step("idle", 4'b0000);

    // Single requester, then the bus returns to the invalid tag.
    set_req(2, 1'b1, 32'hDEADBEEF, 5'd7, 4'd5);
    step("single", 4'b0100);
    clear_all();
    step("single_after", 4'b0000);

    // Flush drops arbitration and resets the pointer to 0.
    set_req(1, 1'b1, 32'h11, 5'd1, 4'd6);
    set_req(2, 1'b1, 32'h22, 5'd2, 4'd7);
    flush = 1'b1;
    step("flush", 4'b0000);
    flush = 1'b0;
    step("flush_g1", 4'b0010);
    step("flush_g2", 4'b0100);
    // Flush with a broadcast already on the bus (checked by the previous step).
    flush = 1'b1;
    step("flush_inflight", 4'b0000);
    flush = 1'b0;
    clear_all();

    // Fairness from ptr=0, including a broadcast to register 0.
    set_req(0, 1'b1, 32'hA0, 5'd0, 4'd1);
    set_req(1, 1'b1, 32'hA1, 5'd3, 4'd2);
    set_req(2, 1'b1, 32'hA2, 5'd4, 4'd3);
    set_req(3, 1'b1, 32'hA3, 5'd5, 4'd4);
    step("fair0", 4'b0001);
    step("fair1", 4'b0010);
    step("fair2", 4'b0100);
    step("fair3", 4'b1000);
    step("fair4", 4'b0001);
    step("fair5", 4'b0010);
    clear_all();

    // Move the pointer to 3, then wrap and skip.
    set_req(2, 1'b1, 32'hB2, 5'd6, 4'd10);
    step("to_ptr3", 4'b0100);
    clear_all();
    set_req(0, 1'b1, 32'hC0, 5'd8, 4'd11);
    set_req(1, 1'b1, 32'hC1, 5'd9, 4'd12);
    step("wrap0", 4'b0001);
    step("wrap1", 4'b0010);
    clear_all();

    // Invalid tag on requester 0 is never granted.
    set_req(0, 1'b1, 32'hD0, 5'd10, 4'd0);
    set_req(2, 1'b1, 32'hD2, 5'd11, 4'd9);
    #1;
    chk("busy_two", 32'(bus.busy_cnt), 32'd2);
    step("inv_tag", 4'b0100);
    set_req(2, 1'b0, 32'hD2, 5'd11, 4'd9);
    step("inv_only", 4'b0000);
    chk("proto_seen", 32'(proto_cnt > 0), 32'd1);
    clear_all();

    // Reset in the middle of a broadcast wins over grant.
    set_req(1, 1'b1, 32'hE1, 5'd12, 4'd13);
    step("pre_rst", 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    step("post_rst", 4'b0010);
    clear_all();
    step("final_idle", 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single register-file write-back port (data, destination register, tag) among N_REQ functional-unit requesters, forming the common data bus (CDB).
- Grants one requester per cycle, round-robin, using a valid/ready handshake.
- Drives a registered broadcast to the register file and to the reservation stations, which snoop the same bus.
- Holds the bus at the invalid tag whenever nothing is broadcast, because the register file's write path matches on the tag level.

Parameters:
- N_REQ, 4, number of requesting functional units (2..8).
- DATA_W, 32, result width (COMMON_WIDTH).
- REG_W, 5, architectural register index width (REG_NUM_WIDTH).
- TAG_W, 4, instruction tag width (INST_TAG_WIDTH).
- TAG_INVALID, 0, tag value meaning "no producer / no broadcast".

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; drops the current cycle's arbitration.
- req_valid  in  N_REQ  requester i has a result pending.
- req_data  in  N_REQ x DATA_W  result value per requester.
- req_reg  in  N_REQ x REG_W  destination register per requester.
- req_tag  in  N_REQ x TAG_W  producing-instruction tag per requester.
- req_ready  out  N_REQ  one-hot grant; the transfer occurs when valid and ready are both high at posedge.
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_data  out  DATA_W  broadcast result (to wd).
- cdb_reg  out  REG_W  broadcast destination (to wr).
- cdb_tag  out  TAG_W  broadcast tag (to w_tag); TAG_INVALID when cdb_valid=0.
- busy_cnt  out  $clog2(N_REQ+1)  number of requesters currently asserting valid (combinational popcount, for perf counters).

Behaviour:
- Reset (rst=1 at posedge):
  - cdb_valid=0, cdb_data=0, cdb_reg=0, cdb_tag=TAG_INVALID.
  - Round-robin pointer ptr=0.
  - req_ready is combinational and forced to all-zero while rst=1.
- Arbitration (combinational):
  - Scan requesters starting at ptr and wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 and req_tag[i]!=TAG_INVALID wins; req_ready[i]=1 and all others are 0.
  - No candidate: req_ready=0.
- Invalid-tag requests: a requester presenting req_valid=1 with req_tag=TAG_INVALID is never granted. Its req_ready stays 0; this is a protocol error and a bench assertion fires.
- Latency: a winner sampled at posedge k appears on the cdb_* outputs from k until k+1 (one cycle, registered). Exactly one broadcast per transfer.
- Idle cycle (no winner, or flush):
  - cdb_valid←0, cdb_tag←TAG_INVALID.
  - cdb_data and cdb_reg hold their previous values (don't-care).
- Pointer update:
  - On a transfer from winner w, ptr←(w+1) mod N_REQ.
  - Otherwise ptr holds.
  - Guarantees every persistent requester is granted within N_REQ cycles.
- Requester obligations: hold valid and payload stable until ready. The arbiter has no internal queue, so it never drops an accepted result.
- Flush:
  - While flush=1, req_ready=0 combinationally.
  - Next cycle cdb_valid=0 and cdb_tag=TAG_INVALID; ptr←0.
  - A broadcast already on the bus in the flush cycle completes normally, since it was registered earlier.
- Reset mid-broadcast: rst has priority over flush and over grant; the outputs return to reset values at that posedge.
- Same tag or register from two requesters: no special handling; they are serialized in round-robin order.
- cdb_reg=0 is broadcast normally, because reservation stations still need the tag; x0 protection is the register file's responsibility.

Decomposition:
- Shared package cdb_pkg:
  - typedef cdb_pkt_t {data[DATA_W], rd[REG_W], tag[TAG_W]}.
  - Constant TAG_INVALID, reused from common_def.h.
- Sub-module rr_picker (N param; inputs req[N] and ptr; outputs one-hot gnt[N] and the winner index). It is purely combinational and is reused later by the issue-stage arbiter.
- cdb_arbiter contains the pointer register, the output pipeline register and the flush/reset priority logic.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, cdb_valid=0, cdb_tag=0; after release, the first grant goes to requester 0.
- Single requester: req_valid=4'b0100, tag=5, reg=7, data=32'hDEADBEEF -> req_ready=4'b0100 in the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_reg=7, cdb_data=DEADBEEF; the following cycle cdb_tag=0.
- Fairness: all 4 requesters valid continuously with ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles; cdb_tag sequence matches their tags; no bubbles.
- Wrap and skip: ptr=3, req_valid=4'b0011 -> grant requester 0, then ptr=1 -> grant requester 1.
- Flush: requesters 1 and 2 valid, flush pulsed for one cycle -> req_ready=0 that cycle, cdb_valid=0 next cycle, ptr=0, then requester 1 is granted first.
- Invalid tag: req_valid=4'b0001 with tag=0 plus requester 2 valid with tag=9 -> only requester 2 is granted; the requester-0 protocol assertion fires; cdb_tag=9.
